// File: rtl/board_setup_ctrl.sv
// Board setup controller: clears a WIDTH x HEIGHT board, scatters NUM_MINES mines chosen by
// a 16-bit LFSR, then writes each safe cell's neighbour mine count.
module board_setup_ctrl #(
    parameter int WIDTH     = 8,
    parameter int HEIGHT    = 8,
    parameter int BUS_WIDTH = 8,
    parameter int NUM_MINES = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [15:0]               seed,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(WIDTH)-1:0]  rd_x,
    output logic [$clog2(HEIGHT)-1:0] rd_y,
    input  logic [BUS_WIDTH-1:0]      rd_value,
    output logic                      wr_en,
    output logic [$clog2(WIDTH)-1:0]  wr_x,
    output logic [$clog2(HEIGHT)-1:0] wr_y,
    output logic [BUS_WIDTH-1:0]      wr_value
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int PW = $clog2(NUM_MINES + 1);
    localparam logic [BUS_WIDTH-1:0] MINE        = '1;
    localparam logic [XW-1:0]        X_LAST      = XW'(WIDTH - 1);
    localparam logic [YW-1:0]        Y_LAST      = YW'(HEIGHT - 1);
    localparam logic [PW-1:0]        PLACED_LAST = PW'(NUM_MINES - 1);
    localparam logic [15:0]          ZERO_SEED   = 16'hACE1;

    if (NUM_MINES < 1 || NUM_MINES > WIDTH * HEIGHT - 1) begin : g_bad_num_mines
        $error("board_setup_ctrl: NUM_MINES must be in 1..WIDTH*HEIGHT-1");
    end
    if (XW + YW > 16) begin : g_bad_board_size
        $error("board_setup_ctrl: board coordinates need more than 16 LFSR bits");
    end

    typedef enum logic [2:0] {IDLE, CLEAR, PLACE, COUNT, FINISH} state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   cx_q, cx_d;
    logic [YW-1:0]   cy_q, cy_d;
    logic [3:0]      slot_q, slot_d;
    logic [PW-1:0]   placed_q, placed_d;
    logic [3:0]      acc_q, acc_d;
    logic [15:0]     lfsr_q, lfsr_d;

    logic [XW-1:0]   next_cx, cand_x;
    logic [YW-1:0]   next_cy, cand_y;
    logic            last_cell, cand_in, nb_in;
    logic [15:0]     lfsr_step;
    int              dx, dy, nx, ny;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cx_q     <= '0;
            cy_q     <= '0;
            slot_q   <= '0;
            placed_q <= '0;
            acc_q    <= '0;
            lfsr_q   <= '0;
        end else begin
            state_q  <= state_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            slot_q   <= slot_d;
            placed_q <= placed_d;
            acc_q    <= acc_d;
            lfsr_q   <= lfsr_d;
        end
    end

    // Scan-order cell stepping, LFSR candidate and the neighbour addressed by the current slot.
    always_comb begin
        last_cell = (cx_q == X_LAST) && (cy_q == Y_LAST);
        next_cx   = (cx_q == X_LAST) ? '0 : cx_q + XW'(1);
        next_cy   = cy_q;
        if (cx_q == X_LAST) begin
            next_cy = (cy_q == Y_LAST) ? '0 : cy_q + YW'(1);
        end

        lfsr_step = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        cand_x    = lfsr_q[XW-1:0];
        cand_y    = lfsr_q[XW+YW-1:XW];
        cand_in   = (int'(cand_x) < WIDTH) && (int'(cand_y) < HEIGHT);

        dx = 0;
        dy = 0;
        case (slot_q)
            4'd0: begin dx = -1; dy = -1; end
            4'd1: dy = -1;
            4'd2: begin dx = 1; dy = -1; end
            4'd3: dx = -1;
            4'd4: dx = 1;
            4'd5: begin dx = -1; dy = 1; end
            4'd6: dy = 1;
            4'd7: begin dx = 1; dy = 1; end
            default: ;
        endcase
        nx    = int'(cx_q) + dx;
        ny    = int'(cy_q) + dy;
        nb_in = (nx >= 0) && (nx < WIDTH) && (ny >= 0) && (ny < HEIGHT);
    end

    always_comb begin
        state_d  = state_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        slot_d   = slot_q;
        placed_d = placed_q;
        acc_d    = acc_q;
        lfsr_d   = lfsr_q;
        busy     = (state_q != IDLE);
        done     = (state_q == FINISH);
        rd_x     = '0;
        rd_y     = '0;
        wr_en    = 1'b0;
        wr_x     = '0;
        wr_y     = '0;
        wr_value = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = CLEAR;
                    lfsr_d   = (seed == 16'h0000) ? ZERO_SEED : seed;
                    cx_d     = '0;
                    cy_d     = '0;
                    slot_d   = '0;
                    placed_d = '0;
                    acc_d    = '0;
                end
            end
            CLEAR: begin
                rd_x  = cx_q;
                rd_y  = cy_q;
                wr_en = 1'b1;
                wr_x  = cx_q;
                wr_y  = cy_q;
                cx_d  = next_cx;
                cy_d  = next_cy;
                if (last_cell) begin
                    state_d = PLACE;
                end
            end
            PLACE: begin
                lfsr_d = lfsr_step;
                // An out-of-range candidate is simply skipped; the read address stays at (0,0).
                if (cand_in) begin
                    rd_x = cand_x;
                    rd_y = cand_y;
                    if (rd_value != MINE) begin
                        wr_en    = 1'b1;
                        wr_x     = cand_x;
                        wr_y     = cand_y;
                        wr_value = MINE;
                        placed_d = placed_q + PW'(1);
                        if (placed_q == PLACED_LAST) begin
                            state_d = COUNT;
                        end
                    end
                end
            end
            COUNT: begin
                rd_x = cx_q;
                rd_y = cy_q;
                if (slot_q != 4'd8) begin
                    if (nb_in) begin
                        rd_x = nx[XW-1:0];
                        rd_y = ny[YW-1:0];
                        if (rd_value == MINE) begin
                            acc_d = acc_q + 4'd1;
                        end
                    end
                    slot_d = slot_q + 4'd1;
                end else begin
                    if (rd_value != MINE) begin
                        wr_en    = 1'b1;
                        wr_x     = cx_q;
                        wr_y     = cy_q;
                        wr_value = BUS_WIDTH'(acc_q);
                    end
                    acc_d  = '0;
                    slot_d = '0;
                    cx_d   = next_cx;
                    cy_d   = next_cy;
                    if (last_cell) begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: doc/board_setup_ctrl.md
BOARD_SETUP_CTRL -- requirements
Module: board_setup_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, board columns (>=2).
REQ-002 SHALL have parameter HEIGHT, default 8, board rows (>=2).
REQ-003 SHALL have parameter BUS_WIDTH, default 8, cell value width (>=4).
REQ-004 SHALL have parameter NUM_MINES, default 10, mines placed; elaboration SHALL fail unless 1 <= NUM_MINES <= WIDTH*HEIGHT-1.
REQ-005 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port start  input  1  one-cycle request to build a new board.
REQ-008 SHALL have port seed  input  16  LFSR seed, sampled when start is accepted.
REQ-009 SHALL have port busy  output  1  high while a build is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse on build completion.
REQ-011 SHALL have port rd_x / rd_y  output  clog2(WIDTH) / clog2(HEIGHT)  board read address.
REQ-012 SHALL have port rd_value  input  BUS_WIDTH  combinational board read data for rd_x/rd_y.
REQ-013 SHALL have port wr_en  output  1  board write strobe; the board captures on the rising edge.
REQ-014 SHALL have port wr_x / wr_y / wr_value  output  clog2(WIDTH) / clog2(HEIGHT) / BUS_WIDTH  board write address and data.

Function
REQ-015 States: IDLE, CLEAR, PLACE, COUNT, FINISH; outputs decoded from registered state and counters only.
REQ-016 MINE encoding: all-ones BUS_WIDTH value; neighbour counts 0..8, zero-extended.
REQ-017 IDLE: start=1 moves to CLEAR next edge and loads the LFSR with seed, or with 16'hACE1 if seed==0; busy=1 from the following cycle until FINISH inclusive.
REQ-018 start while not IDLE: ignored, no effect on state, counters or LFSR.
REQ-019 Cell scan order: index = y*WIDTH + x, x fastest, from (0,0) to (WIDTH-1,HEIGHT-1).
REQ-020 CLEAR: one cell per cycle, wr_en=1, wr_value=0, in scan order; exactly WIDTH*HEIGHT cycles, then PLACE.
REQ-021 LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts once every PLACE cycle; candidate x = lfsr[clog2(WIDTH)-1:0], y = next clog2(HEIGHT) bits.
REQ-022 PLACE: rd_x/rd_y = candidate; if candidate is in range and rd_value != MINE, drive wr_en=1, wr_x/wr_y = candidate, wr_value=MINE, and increment placed; otherwise wr_en=0.
REQ-023 PLACE exits to COUNT on the edge that commits the NUM_MINES-th mine; no extra mine is ever written.
REQ-024 COUNT: per cell, 8 neighbour slots in order (-1,-1),(0,-1),(+1,-1),(-1,0),(+1,0),(-1,+1),(0,+1),(+1,+1), one cycle each, then 1 write cycle; exactly 9*WIDTH*HEIGHT cycles total.
REQ-025 Neighbour slot: in bounds, rd = neighbour address and accumulator += (rd_value==MINE); out of bounds (edge/corner), rd = centre cell and accumulator unchanged; rd_x<WIDTH and rd_y<HEIGHT at all times.
REQ-026 Write cycle: rd = centre; if rd_value==MINE then wr_en=0, else wr_en=1 with wr_value=accumulator; accumulator clears for the next cell.
REQ-027 After the last cell, FINISH for one cycle: done=1, busy=1, wr_en=0; then IDLE.
REQ-028 wr_en SHALL be 0 in IDLE and FINISH.

Reset
REQ-029 reset asserted at any time: state=IDLE; busy=0, done=0, wr_en=0, rd_x=rd_y=0, wr_x=wr_y=0, wr_value=0; counters, accumulator and LFSR cleared.
REQ-030 Reset mid-build abandons the build; the next accepted start produces the same board as an uninterrupted build with the same seed.

Verification
REQ-031 Reset pulse -> all outputs 0 and IDLE; start with 8x8 defaults and seed=16'h0001 -> busy high and wr_en=1 with wr_value=0 for 64 cycles, addresses (0,0)..(7,7).
REQ-032 Same run to done -> exactly 10 cells equal 8'hFF; every other cell equals its reference-model neighbour mine count; busy length = 64 + P + 576 + 1, where P is the number of PLACE cycles.
REQ-033 seed=16'h0000 vs seed=16'hACE1 -> identical final boards and identical cycle counts.
REQ-034 start pulses during CLEAR, PLACE and COUNT -> no change in trace compared with a run without them; a start on the done cycle is ignored, and start one cycle later is accepted.
REQ-035 Corner and edge checks: a mine at (0,0) yields count 1 at (1,0), (0,1) and (1,1); rd addresses never leave range at any cycle; every out-of-bounds slot reads the centre cell.
REQ-036 Assert reset for 1 cycle mid-COUNT, then start with seed=16'h0001 -> final board bit-identical to the result of REQ-032.
